muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit; the multi-cycle responder beside the single-cycle integer ALU.
- Decode issues an operation when funct7 == 0000001 on an OP instruction. The core stalls until the result returns.
- Valid/ready request and response handshakes. Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width. Only 32 is supported; width-dependent constants derive from it.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  operation offered
- req_ready  out  1  unit can accept (high only in IDLE)
- a  in  XLEN  rs1 operand
- b  in  XLEN  rs2 operand
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- flush  in  1  abort any in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  core takes result
- out  out  XLEN  result
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, any state): state = IDLE, resp_valid = 0, out = 0, busy = 0, all internal registers = 0. req_ready = 1 once reset deasserts.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On edge E0 with req_valid & req_ready & !flush: latch funct3, operand signs, |a|, |b| (signedness per op; MULHSU treats a signed, b unsigned).
  - Clear the 2*XLEN accumulator and cnt = 0, then go to CALC.
- Special cases, checked at acceptance (go straight to DONE, resp_valid high after E1):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give a.
  - Signed overflow (DIV/REM, a = 0x80000000, b = 0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC, one iteration per cycle, cnt increments, 32 cycles (E1..E32), then FIX:
  - Multiply: add multiplicand when multiplier LSB = 1, shift right.
  - Divide: shift remainder:quotient left, trial-subtract divisor, set quotient bit when non-negative.
- FIX (E33), then DONE:
  - Negate the product when the operand signs differ (signed ops).
  - Quotient sign = sign_a ^ sign_b; remainder takes sign of a.
  - Select low word (MUL), high word (MULH*), quotient or remainder into out.
- DONE:
  - resp_valid = 1 and out is stable until resp_ready. Normal latency: resp_valid high after E33.
  - On an edge with resp_ready: resp_valid = 0 and state = IDLE. A new request is accepted no earlier than the following edge; no same-cycle turnaround.
- flush: on any edge where flush = 1 and state != IDLE, state = IDLE and resp_valid = 0 on that edge. flush in IDLE blocks acceptance that cycle. flush beats resp_ready.
- Inputs a, b, funct3 are ignored outside the acceptance edge. Changing them mid-operation has no effect.
- cnt is $clog2(XLEN)+1 bits and never wraps. CALC exits exactly when cnt reaches XLEN-1.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed product computed at acceptance. Go straight to DONE; resp_valid high after E1. Divide path unchanged.
- Undefined: all multiplies are iterative with 33-cycle latency. No multiplier is inferred.

Decomposition:
- Package muldiv_pkg:
  - funct3 localparams (F3_MUL..F3_REMU).
  - state_t enum {IDLE, CALC, FIX, DONE}.
  - XLEN-derived constants: ITER_LAST, INT_MIN.
- One combinational sub-module muldiv_step:
  - Computes the next accumulator for one multiply or divide iteration from {acc, operand, is_div}.
  - Keeps the FSM file to control and sign handling only.

Test Plan:
- MUL a=7, b=0xFFFFFFFD (-3) -> out 0xFFFFFFEB; resp_valid rises 33 cycles after acceptance (1 with MULDIV_FAST_MUL_EN).
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Signed divide: DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Boundary cases:
  - DIVU 0x1234/0 -> 0xFFFFFFFF and REMU 0x1234/0 -> 0x1234.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
  - Each responds one cycle after acceptance.
- Backpressure: hold resp_ready = 0 for 10 cycles in DONE -> resp_valid and out stable, req_ready = 0. Assert resp_ready -> IDLE next edge, req_ready = 1.
- Flush and reset:
  - flush at cnt = 15 -> IDLE next edge, resp_valid never rises. Next request (DIVU 9/3) -> 3.
  - Async reset mid-CALC -> outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared constants, opcodes and state encoding for the RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNT_W     = $clog2(XLEN) + 1;
    localparam int unsigned ITER_LAST = XLEN - 1;
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring-divide step on the 2*XLEN accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  logic              ser_bit,
    input  logic              is_div,
    output logic [2*XLEN-1:0] acc_next
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        // ser_bit is the next dividend bit shifted into the partial remainder
        rem_sh   = {acc[2*XLEN-1:XLEN], ser_bit};
        fits     = rem_sh >= {1'b0, operand};
        diff     = rem_sh[XLEN-1:0] - operand;
        acc_next = acc;
        if (is_div) begin
            if (fits) acc_next = {diff, acc[XLEN-2:0], 1'b1};
            else      acc_next = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else if (ser_bit) begin
            acc_next = {sum, acc[XLEN-1:1]};
        end else begin
            acc_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready request and response handshakes.
// MULDIV_FAST_MUL_EN: multiplies complete with a single-cycle 33x33 signed product.
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      funct3,
    input  logic            flush,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] out,
    output logic            busy
);

    state_t            state;
    logic [2:0]        f3;
    logic              sign_a;
    logic              sign_b;
    logic [XLEN-1:0]   op;
    logic [XLEN-1:0]   ser;
    logic [2*XLEN-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic              a_signed, b_signed, sa, sb, req_div, div_zero, div_ovf;
    logic [XLEN-1:0]   mag_a, mag_b, special_out, fix_out;
    logic [2*XLEN-1:0] acc_next, prod;

    // Request decode, evaluated on the acceptance edge only
    always_comb begin
        a_signed    = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
                      (funct3 == F3_DIV)  || (funct3 == F3_REM);
        b_signed    = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
        sa          = a_signed & a[XLEN-1];
        sb          = b_signed & b[XLEN-1];
        mag_a       = magnitude(a, sa);
        mag_b       = magnitude(b, sb);
        req_div     = funct3[2];
        div_zero    = req_div && (b == '0);
        div_ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) && (a == INT_MIN) && (b == '1);
        special_out = '0;
        if (div_zero)     special_out = funct3[1] ? a : '1;
        else if (div_ovf) special_out = funct3[1] ? '0 : INT_MIN;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_a, fast_b, fast_prod;
    logic [XLEN-1:0]          fast_out;
    logic                     unused_fast;

    always_comb begin
        fast_a      = (2*XLEN+2)'($signed({sa, a}));
        fast_b      = (2*XLEN+2)'($signed({sb, b}));
        fast_prod   = fast_a * fast_b;
        fast_out    = (funct3 == F3_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
        unused_fast = ^fast_prod[2*XLEN+1:2*XLEN];
    end
`endif

    muldiv_step u_step (
        .acc      (acc),
        .operand  (op),
        .ser_bit  (f3[2] ? ser[XLEN-1] : ser[0]),
        .is_div   (f3[2]),
        .acc_next (acc_next)
    );

    // Sign fix-up and word selection of the finished accumulator
    always_comb begin
        prod    = (sign_a ^ sign_b) ? -acc : acc;
        fix_out = '0;
        case (f3)
            F3_MUL:                       fix_out = prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: fix_out = prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              fix_out = (sign_a ^ sign_b) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:                      fix_out = sign_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            f3         <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            op         <= '0;
            ser        <= '0;
            acc        <= '0;
            cnt        <= '0;
            out        <= '0;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else if (flush && (state != IDLE)) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready && !flush) begin
                        f3        <= funct3;
                        sign_a    <= sa;
                        sign_b    <= sb;
                        op        <= req_div ? mag_b : mag_a;
                        ser       <= req_div ? mag_a : mag_b;
                        acc       <= '0;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (div_zero || div_ovf) begin
                            out        <= special_out;
                            resp_valid <= 1'b1;
                            state      <= DONE;
`ifdef MULDIV_FAST_MUL_EN
                        end else if (!req_div) begin
                            out        <= fast_out;
                            resp_valid <= 1'b1;
                            state      <= DONE;
`endif
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CNT_W'(1);
                    ser <= f3[2] ? {ser[XLEN-2:0], 1'b0} : {1'b0, ser[XLEN-1:1]};
                    if (cnt == CNT_W'(ITER_LAST)) state <= FIX;
                end
                FIX: begin
                    out        <= fix_out;
                    resp_valid <= 1'b1;
                    state      <= DONE;
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M vectors, randomized ops vs. an arithmetic model,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  funct3 = '0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] out;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .funct3     (funct3),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .out        (out),
        .busy       (busy)
    );

    // Reference result from plain 64-bit arithmetic on the RV32M definitions
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, ux, uy, p;
        logic [31:0] r;
        logic ovf;
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        ux  = {32'b0, x};
        uy  = {32'b0, y};
        ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            3'b000: begin p = sx * sy; r = p[31:0];  end
            3'b001: begin p = sx * sy; r = p[63:32]; end
            3'b010: begin p = sx * uy; r = p[63:32]; end
            3'b011: begin p = ux * uy; r = p[63:32]; end
            3'b100: r = (y == 0) ? 32'hFFFF_FFFF : (ovf ? x : 32'($signed(x) / $signed(y)));
            3'b101: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'b110: r = (y == 0) ? x : (ovf ? 32'd0 : 32'($signed(x) % $signed(y)));
            default: r = (y == 0) ? x : x % y;
        endcase
        return r;
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2] && (y == 0)) return 1;
        if ((f == 3'b100 || f == 3'b110) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    // Issue one request, scramble inputs after acceptance, wait for response, then consume it
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output int lat, output bit got);
        @(negedge clk);
        funct3 = f; a = x; b = y; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        a = $urandom; b = $urandom; funct3 = 3'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!resp_valid && lat < 100);
        got = resp_valid;
        res = out;
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (out !== 32'd0) begin n_fail++; $display("FAIL reset_out: got %h want 0", out); end
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_directed();
        logic [2:0]  tf [14] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101,
                                 3'b111, 3'b101, 3'b111, 3'b100, 3'b110, 3'b100, 3'b110};
        logic [31:0] ta [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000,
                                 32'd5, 32'hFFFF_FFFB};
        logic [31:0] tb [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] te [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'd0,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] res;
        int lat;
        bit got;
        for (int i = 0; i < 14; i++) begin
            run_op(tf[i], ta[i], tb[i], res, lat, got);
            n_tests++;
            if (!got || res !== te[i]) begin
                n_fail++;
                $display("FAIL directed_out[%0d] f3=%0d: got %h (valid %b) want %h", i, tf[i], res, got, te[i]);
            end
            n_tests++;
            if (lat !== exp_lat(tf[i], ta[i], tb[i])) begin
                n_fail++;
                $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, exp_lat(tf[i], ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] x, y, res, want;
        int lat;
        bit got;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = rnd_operand();
            y = rnd_operand();
            want = model(f, x, y);
            run_op(f, x, y, res, lat, got);
            n_tests++;
            if (!got || res !== want || lat !== exp_lat(f, x, y)) begin
                n_fail++;
                $display("FAIL random[%0d] f3=%0d a=%h b=%h: got %h lat %0d want %h lat %0d",
                         i, f, x, y, res, lat, want, exp_lat(f, x, y));
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        funct3 = 3'b101; a = 32'd100; b = 32'd7; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 100);
        n_tests++;
        if (lat !== 33) begin n_fail++; $display("FAIL bp_latency: got %0d want 33", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_tests++;
            if ({resp_valid, req_ready, out} !== {1'b1, 1'b0, 32'd14}) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got valid %b ready %b out %h want 1 0 %h",
                         i, resp_valid, req_ready, out, 32'd14);
            end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        funct3 = 3'b101; a = 32'd9; b = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: got valid %b ready %b want 0 1", resp_valid, req_ready);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bp_no_turnaround: got busy %b want 0", busy); end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept_next: got busy %b want 1", busy); end
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!resp_valid && lat < 100);
        n_tests++;
        if (!resp_valid || out !== 32'd3) begin
            n_fail++;
            $display("FAIL bp_second_out: got %h (valid %b) want 3", out, resp_valid);
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [31:0] res;
        int lat;
        bit got;
        bit seen;
        @(negedge clk);
        funct3 = 3'b101; a = 32'd1000; b = 32'd3; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        n_tests++;
        if ({busy, req_ready, resp_valid} !== 3'b010) begin
            n_fail++;
            $display("FAIL flush_idle: got busy %b ready %b valid %b want 0 1 0", busy, req_ready, resp_valid);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (resp_valid) seen = 1'b1;
        end
        n_tests++;
        if (seen) begin n_fail++; $display("FAIL flush_no_resp: got resp_valid 1 want 0"); end
        @(negedge clk);
        funct3 = 3'b101; a = 32'd9; b = 32'd3; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        flush = 1'b0;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_blocks_accept: got busy %b want 0", busy); end
        run_op(3'b101, 32'd9, 32'd3, res, lat, got);
        n_tests++;
        if (!got || res !== 32'd3 || lat !== 33) begin
            n_fail++;
            $display("FAIL flush_next_op: got %h lat %0d want 3 lat 33", res, lat);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int lat;
        bit got;
        @(negedge clk);
        funct3 = 3'b011; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        n_tests++;
        if (busy !== 1'b1 || out === 32'd0) begin
            n_fail++;
            $display("FAIL areset_precond: got busy %b out %h want busy 1 out nonzero", busy, out);
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({busy, resp_valid, out} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL areset_immediate: got busy %b valid %b out %h want 0 0 0", busy, resp_valid, out);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", req_ready); end
        run_op(3'b000, 32'd7, 32'hFFFF_FFFD, res, lat, got);
        n_tests++;
        if (!got || res !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL areset_recover: got %h want ffffffeb", res);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
